// File: rtl/key_select_ctrl.sv
// key_select_ctrl
// Debounces NUM_KEYS active-low push-buttons and keeps a one-hot selection
// over NUM_SEL options for the DDS waveform/ROM-select logic.
//
// There are two modes. In direct mode, key i selects option i. In cycle mode,
// key0 means next and key1 means prev. Both wrap around, and holding either
// key auto-repeats.
//
// Ports:
//   sys_clk      system clock
//   sys_rst_n    synchronous active-low reset
//   key_n        raw asynchronous key levels, 0 = pressed
//   mode         0 = direct, 1 = cycle
//   sel_onehot   one-hot current selection, all-zero when none
//   sel_index    binary index of the current selection
//   sel_valid    a selection has been made since reset
//   sel_changed  one-cycle pulse the cycle after sel_onehot changes
//   key_event    per-key accepted-press pulse, including auto-repeat steps
module key_select_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SEL         = 4,
    parameter int DEBOUNCE_CYCLES = 999_999,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int IDX_W           = $clog2(NUM_SEL)
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                mode,
    output logic [NUM_SEL-1:0]  sel_onehot,
    output logic [IDX_W-1:0]    sel_index,
    output logic                sel_valid,
    output logic                sel_changed,
    output logic [NUM_KEYS-1:0] key_event
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_ARM   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER  = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEL - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] blocked;
    logic [1:0]          settle;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rpt_vec;

    logic [1:0]          rpt_active;
    logic [1:0]          rpt_first;
    logic [RPT_W-1:0]    rpt_cnt [2];
    logic [1:0]          rpt_fire;
    logic                mode_q;

    logic [NUM_SEL-1:0]  onehot_q;
    logic                upd;
    logic [IDX_W-1:0]    next_idx;

    // A press is accepted on the step of the counter from DEBOUNCE_CYCLES-2
    // to DEBOUNCE_CYCLES-1.
    //
    // Auto-repeat fires once the hold reaches the delay, and after that once
    // per period. It is suppressed on the cycle the mode changes.
    always_comb begin
        press    = '0;
        rpt_fire = '0;
        rpt_vec  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            press[i] = !blocked[i] && !sync2[i] && (db_cnt[i] == DB_ARM);
        end
        for (int j = 0; j < 2; j++) begin
            rpt_fire[j] = mode && (mode == mode_q) && rpt_active[j] && !sync2[j] &&
                          (rpt_cnt[j] == (rpt_first[j] ? RPT_DLY : RPT_PER));
        end
        rpt_vec[1:0] = rpt_fire;
    end

    // Synchronizers and debounce counters.
    //
    // After reset, each key stays blocked until its synchronized level reads
    // released. The settle shift register is there because the synchronizer
    // still holds its reset value for the first two cycles. Without it, a key
    // held through reset could be mistaken for released.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            settle    <= '0;
            blocked   <= '1;
            key_event <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1     <= key_n;
            sync2     <= sync1;
            settle    <= {settle[0], 1'b1};
            key_event <= press | rpt_vec;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (settle[1] && sync2[i]) begin
                    blocked[i] <= 1'b0;
                end
                if (sync2[i] || blocked[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat timers for next/prev.
    //
    // Each timer is armed by an accepted press. It is cleared by release,
    // by direct mode, or by any mode change.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rpt_active <= '0;
            rpt_first  <= '0;
            mode_q     <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                rpt_cnt[j] <= '0;
            end
        end else begin
            mode_q <= mode;
            for (int j = 0; j < 2; j++) begin
                if ((mode != mode_q) || !mode || sync2[j]) begin
                    rpt_active[j] <= 1'b0;
                    rpt_cnt[j]    <= '0;
                end else if (press[j]) begin
                    rpt_active[j] <= 1'b1;
                    rpt_first[j]  <= 1'b1;
                    rpt_cnt[j]    <= '0;
                end else if (rpt_fire[j]) begin
                    rpt_first[j] <= 1'b0;
                    rpt_cnt[j]   <= '0;
                end else if (rpt_active[j]) begin
                    rpt_cnt[j] <= rpt_cnt[j] + 1'b1;
                end
            end
        end
    end

    // Next-selection decision.
    //
    // In direct mode, the loop runs downwards so that the lowest actionable
    // key is the one left standing.
    always_comb begin
        upd      = 1'b0;
        next_idx = sel_index;
        if (!mode) begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if ((i < NUM_SEL) && key_event[i]) begin
                    upd      = 1'b1;
                    next_idx = IDX_W'(i);
                end
            end
        end else if (key_event[0]) begin
            upd = 1'b1;
            if (!sel_valid || (sel_index == LAST_IDX)) begin
                next_idx = '0;
            end else begin
                next_idx = sel_index + 1'b1;
            end
        end else if (key_event[1]) begin
            upd = 1'b1;
            if (!sel_valid || (sel_index == '0)) begin
                next_idx = LAST_IDX;
            end else begin
                next_idx = sel_index - 1'b1;
            end
        end
    end

    // Selection registers.
    //
    // sel_changed compares against a delayed copy of sel_onehot, so the pulse
    // lands exactly one cycle after the change.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel_onehot  <= '0;
            sel_index   <= '0;
            sel_valid   <= 1'b0;
            sel_changed <= 1'b0;
            onehot_q    <= '0;
        end else begin
            onehot_q    <= sel_onehot;
            sel_changed <= (sel_onehot != onehot_q);
            if (upd && (!sel_valid || (next_idx != sel_index))) begin
                sel_index  <= next_idx;
                sel_onehot <= {{(NUM_SEL-1){1'b0}}, 1'b1} << next_idx;
                sel_valid  <= 1'b1;
            end
        end
    end

endmodule
